decoder_scoreboard: RTL and testbench
=====================================

Name: decoder_scoreboard

Overview:
- Parametrised register-busy scoreboard for the MIPS pipeline; generalises the fixed 5→32 / 6→64 one-hot decoders.
- Sits between decode/issue and writeback: marks a destination register busy on issue and clears it on writeback.
- Answers NUM_RD source-operand busy queries per cycle and raises a stall request on RAW or WAW hazards.
- Internally: registered busy bitmap, updated each cycle through parametrised index→one-hot decode.

Parameters:
- IDX_W, 5, register index width.
- N, 1<<IDX_W, number of tracked registers; must equal 2**IDX_W.
- NUM_RD, 2, number of source query ports.
- HARDWIRE_ZERO, 1, when 1 register 0 is never marked busy (MIPS $zero).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- set_valid  in  1  issue of an instruction that writes set_idx.
- set_idx  in  IDX_W  destination register being issued.
- clr_valid  in  1  writeback completing for clr_idx.
- clr_idx  in  IDX_W  register written back.
- rd_en  in  NUM_RD  per-port query enable.
- rd_idx  in  NUM_RD*IDX_W  packed source indices; port k at [k*IDX_W +: IDX_W].
- rd_busy  out  NUM_RD  per-port busy flag.
- busy_vec  out  N  current busy bitmap, bit i = register i.
- busy_cnt  out  IDX_W+1  popcount of busy_vec.
- stall  out  1  hazard: issue must hold.

Behaviour:
- Reset: the only clock/reset is clk; reset is synchronous and active-high. On a rising clk edge with reset=1: busy_vec=0, busy_cnt=0. reset overrides set/clr in the same cycle. Asserting reset while registers are pending drops all pending state, with no residual effect.
- Update on each rising edge with reset=0: busy_vec_next = (busy_vec & ~dec(clr)) | dec(set).
  - dec(x) is the N-bit one-hot of x_idx, gated by x_valid.
  - If HARDWIRE_ZERO=1, bit 0 of dec(set) is forced to 0, so busy_vec[0] stays 0 permanently.
- Simultaneous set_valid and clr_valid with set_idx==clr_idx: set wins, and the bit is 1 after the edge (the new producer supersedes the old).
- Clear of a non-busy register: no effect, no error.
- Set of an already busy register: the bit stays 1, no count change. The stall rule prevents this in normal flow.
- busy_cnt: registered. Updated on the same edge to the popcount of busy_vec_next, so it is always consistent with busy_vec (max N, or N-1 when HARDWIRE_ZERO=1).
- rd_busy[k]: combinational = rd_en[k] & busy_vec[rd_idx_k]. The same-cycle clr is not visible unless the optional feature is enabled.
- stall: combinational = |rd_busy | (set_valid & busy_vec[set_idx]).
  - The set term is the WAW hazard.
  - The set term is masked for set_idx==0 when HARDWIRE_ZERO=1.
- stall does not gate the update. The upstream stage must deassert set_valid while stall=1; the block does not check this.
- Latency: a set or clr becomes visible on rd_busy, busy_vec and busy_cnt one cycle after it is presented.

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: a same-cycle clear is forwarded combinationally.
  - rd_busy[k] = rd_en[k] & busy_vec[rd_idx_k] & ~(clr_valid & clr_idx==rd_idx_k).
  - The WAW term of stall is masked the same way when clr_idx==set_idx.
  - busy_vec and busy_cnt remain the registered values.
- Undefined: no forwarding; a cleared register still reads busy in its clr cycle, costing one extra stall cycle.

Test Plan:
- Reset, then idle → busy_vec=0, busy_cnt=0, rd_busy=0, stall=0. Then apply reset mid-run with 3 registers busy → all outputs 0 on the next cycle.
- set_valid=1, set_idx=5 for one cycle, then rd_en=01, rd_idx[0]=5 → next cycle rd_busy[0]=1, busy_vec=0x20, busy_cnt=1, stall=1.
- From the previous state: clr_valid=1, clr_idx=5 with the query held → with SB_WB_BYPASS_EN, rd_busy[0]=0 that cycle; without it, rd_busy[0]=1 that cycle and 0 the next; busy_cnt=0 afterwards.
- Simultaneous set_idx=clr_idx=7 with bit 7 initially busy → bit 7 remains 1, busy_cnt unchanged.
- set_valid=1, set_idx=0 with HARDWIRE_ZERO=1 → busy_vec[0]=0, stall=0, busy_cnt=0. Repeat with HARDWIRE_ZERO=0 → bit 0 set, busy_cnt=1.
- IDX_W=6, NUM_RD=3: set all 64 registers over 64 cycles → busy_cnt=64 with HARDWIRE_ZERO=0, or 63 with HARDWIRE_ZERO=1. Then query 3 distinct indices → all rd_busy=1.

Source files
------------

// File: rtl/decoder_scoreboard.sv
// Register-busy scoreboard: one-hot decoded set/clear of a registered busy bitmap,
// source-operand busy queries and a RAW/WAW stall request. Optional macro: SB_WB_BYPASS_EN.
module decoder_scoreboard #(
   parameter int IDX_W         = 5,
   parameter int N             = 1 << IDX_W,
   parameter int NUM_RD        = 2,
   parameter bit HARDWIRE_ZERO = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    set_valid,
   input  logic [IDX_W-1:0]        set_idx,
   input  logic                    clr_valid,
   input  logic [IDX_W-1:0]        clr_idx,
   input  logic [NUM_RD-1:0]       rd_en,
   input  logic [NUM_RD*IDX_W-1:0] rd_idx,
   output logic [NUM_RD-1:0]       rd_busy,
   output logic [N-1:0]            busy_vec,
   output logic [IDX_W:0]          busy_cnt,
   output logic                    stall
);

   function automatic logic [IDX_W:0] popcount(input logic [N-1:0] v);
      logic [IDX_W:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + {{IDX_W{1'b0}}, v[i]};
      end
      return c;
   endfunction

   logic [N-1:0]      busy_q, busy_d;
   logic [N-1:0]      set_dec, clr_dec;
   logic [IDX_W:0]    cnt_q, cnt_d;
   logic [NUM_RD-1:0] rd_busy_s;
   logic              waw_s;

   // Next bitmap: clear first, then set, so a same-index set supersedes the clear.
   always_comb begin
      set_dec = '0;
      clr_dec = '0;
      if (set_valid) begin
         set_dec[set_idx] = 1'b1;
      end else begin
         set_dec = '0;
      end
      if (HARDWIRE_ZERO) begin
         set_dec[0] = 1'b0;
      end else begin
         set_dec[0] = set_dec[0];
      end
      if (clr_valid) begin
         clr_dec[clr_idx] = 1'b1;
      end else begin
         clr_dec = '0;
      end
      busy_d = (busy_q & ~clr_dec) | set_dec;
      cnt_d  = popcount(busy_d);
   end

   // Busy bitmap and its popcount register together so they never disagree.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // Source queries (RAW) and destination-busy check (WAW).
   always_comb begin
      rd_busy_s = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rd_busy_s[k] = rd_en[k] & busy_q[rd_idx[k*IDX_W +: IDX_W]];
`ifdef SB_WB_BYPASS_EN
         if (clr_valid && (clr_idx == rd_idx[k*IDX_W +: IDX_W])) begin
            rd_busy_s[k] = 1'b0;
         end else begin
            rd_busy_s[k] = rd_busy_s[k];
         end
`endif
      end
      waw_s = set_valid & busy_q[set_idx];
      if (HARDWIRE_ZERO && (set_idx == '0)) begin
         waw_s = 1'b0;
      end else begin
         waw_s = waw_s;
      end
`ifdef SB_WB_BYPASS_EN
      if (clr_valid && (clr_idx == set_idx)) begin
         waw_s = 1'b0;
      end else begin
         waw_s = waw_s;
      end
`endif
   end

   assign rd_busy  = rd_busy_s;
   assign stall    = (|rd_busy_s) | waw_s;
   assign busy_vec = busy_q;
   assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_decoder_scoreboard.sv
// Randomized + directed bench for decoder_scoreboard against a behavioural busy-set model.
// Instance 0: defaults (32 regs, 2 ports, $zero hardwired); instance 1: 64 regs, 3 ports, no hardwire.
module tb_decoder_scoreboard;

`ifdef SB_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam int NREG[2] = '{32, 64};
   localparam int NRD[2]  = '{2, 3};
   localparam bit HZ[2]   = '{1'b1, 1'b0};

   logic clk = 1'b0;
   logic reset;
   logic       set_v[2];
   logic [5:0] set_i[2];
   logic       clr_v[2];
   logic [5:0] clr_i[2];
   logic [2:0] rd_en_a[2];
   logic [5:0] rd_i[2][3];

   logic [1:0]  rb0;
   logic [31:0] bv0;
   logic [5:0]  cnt0;
   logic        st0;
   logic [2:0]  rb1;
   logic [63:0] bv1;
   logic [6:0]  cnt1;
   logic        st1;

   int checks = 0;
   int errors = 0;
   bit busy_m[2][64];
   bit mvalid = 1'b0;

   always #5 clk = ~clk;

   decoder_scoreboard dut0 (
      .clk(clk), .reset(reset),
      .set_valid(set_v[0]), .set_idx(set_i[0][4:0]),
      .clr_valid(clr_v[0]), .clr_idx(clr_i[0][4:0]),
      .rd_en(rd_en_a[0][1:0]), .rd_idx({rd_i[0][1][4:0], rd_i[0][0][4:0]}),
      .rd_busy(rb0), .busy_vec(bv0), .busy_cnt(cnt0), .stall(st0)
   );

   decoder_scoreboard #(.IDX_W(6), .NUM_RD(3), .HARDWIRE_ZERO(1'b0)) dut1 (
      .clk(clk), .reset(reset),
      .set_valid(set_v[1]), .set_idx(set_i[1]),
      .clr_valid(clr_v[1]), .clr_idx(clr_i[1]),
      .rd_en(rd_en_a[1]), .rd_idx({rd_i[1][2], rd_i[1][1], rd_i[1][0]}),
      .rd_busy(rb1), .busy_vec(bv1), .busy_cnt(cnt1), .stall(st1)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected outputs from the set of busy registers and the current request inputs.
   task automatic model_check(input int u, input logic [63:0] bv, input logic [6:0] cnt,
                              input logic [2:0] rb, input logic st);
      logic [63:0] ebv;
      int          ecnt;
      logic [2:0]  erb;
      logic        est;
      ebv = 64'h0;
      ecnt = 0;
      erb = 3'b000;
      for (int i = 0; i < NREG[u]; i++) begin
         ebv[i] = busy_m[u][i];
         ecnt += int'(busy_m[u][i]);
      end
      for (int k = 0; k < NRD[u]; k++) begin
         erb[k] = rd_en_a[u][k] && busy_m[u][rd_i[u][k]]
                  && !(BYP && clr_v[u] && clr_i[u] == rd_i[u][k]);
      end
      est = (erb != 3'b000)
            || (set_v[u] && busy_m[u][set_i[u]] && !(HZ[u] && set_i[u] == 6'd0)
                && !(BYP && clr_v[u] && clr_i[u] == set_i[u]));
      chk($sformatf("u%0d busy_vec", u), bv, ebv);
      chk($sformatf("u%0d busy_cnt", u), {57'b0, cnt}, 64'(ecnt));
      chk($sformatf("u%0d rd_busy", u), {61'b0, rb}, {61'b0, erb});
      chk($sformatf("u%0d stall", u), {63'b0, st}, {63'b0, est});
   endtask

   task automatic model_step(input int u);
      if (reset) begin
         for (int i = 0; i < 64; i++) busy_m[u][i] = 1'b0;
      end else begin
         if (clr_v[u]) busy_m[u][clr_i[u]] = 1'b0;
         if (set_v[u] && !(HZ[u] && set_i[u] == 6'd0)) busy_m[u][set_i[u]] = 1'b1;
      end
   endtask

   // Compare on the falling edge, then advance the model to what the next rising edge stores.
   always @(negedge clk) begin
      if (mvalid) begin
         model_check(0, {32'b0, bv0}, {1'b0, cnt0}, {1'b0, rb0}, st0);
         model_check(1, bv1, cnt1, rb1, st1);
      end
      model_step(0);
      model_step(1);
      if (reset) mvalid = 1'b1;
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic obs;
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      for (int u = 0; u < 2; u++) begin
         set_v[u] = 1'b0; set_i[u] = 6'd0;
         clr_v[u] = 1'b0; clr_i[u] = 6'd0;
         rd_en_a[u] = 3'b000;
         for (int k = 0; k < 3; k++) rd_i[u][k] = 6'd0;
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      cyc(); cyc();
      reset = 1'b0;
      obs();
      chk("idle bv0", {32'b0, bv0}, 64'h0);
      chk("idle cnt0", {58'b0, cnt0}, 64'h0);
      chk("idle rb0", {62'b0, rb0}, 64'h0);
      chk("idle st0", {63'b0, st0}, 64'h0);

      cyc(); set_v[0] = 1'b1; set_i[0] = 6'd5;
      cyc(); set_v[0] = 1'b0; rd_en_a[0] = 3'b001; rd_i[0][0] = 6'd5;
      obs();
      chk("set5 bv0", {32'b0, bv0}, 64'h20);
      chk("set5 cnt0", {58'b0, cnt0}, 64'd1);
      chk("set5 rb0", {63'b0, rb0[0]}, 64'd1);
      chk("set5 st0", {63'b0, st0}, 64'd1);

      cyc(); clr_v[0] = 1'b1; clr_i[0] = 6'd5;
      obs();
      chk("clr5 same-cycle rb0", {63'b0, rb0[0]}, BYP ? 64'd0 : 64'd1);
      cyc(); clr_v[0] = 1'b0;
      obs();
      chk("clr5 after rb0", {63'b0, rb0[0]}, 64'd0);
      chk("clr5 after cnt0", {58'b0, cnt0}, 64'd0);

      cyc(); set_v[0] = 1'b1; set_i[0] = 6'd7;
      cyc(); clr_v[0] = 1'b1; clr_i[0] = 6'd7;
      cyc(); set_v[0] = 1'b0; clr_v[0] = 1'b0;
      obs();
      chk("set/clr7 bit7", {63'b0, bv0[7]}, 64'd1);
      chk("set/clr7 cnt0", {58'b0, cnt0}, 64'd1);

      cyc(); set_v[0] = 1'b1; set_i[0] = 6'd0; clr_v[0] = 1'b1; clr_i[0] = 6'd7;
      set_v[1] = 1'b1; set_i[1] = 6'd0;
      obs();
      chk("zero st0", {63'b0, st0}, 64'd0);
      cyc(); set_v[0] = 1'b0; clr_v[0] = 1'b0; set_v[1] = 1'b0;
      obs();
      chk("zero bit0 u0", {63'b0, bv0[0]}, 64'd0);
      chk("zero cnt0", {58'b0, cnt0}, 64'd0);
      chk("zero bit0 u1", {63'b0, bv1[0]}, 64'd1);
      chk("zero cnt1", {57'b0, cnt1}, 64'd1);

      for (int i = 0; i < 64; i++) begin
         cyc(); set_v[1] = 1'b1; set_i[1] = 6'(i);
      end
      cyc(); set_v[1] = 1'b0;
      rd_en_a[1] = 3'b111; rd_i[1][0] = 6'd3; rd_i[1][1] = 6'd40; rd_i[1][2] = 6'd63;
      obs();
      chk("fill cnt1", {57'b0, cnt1}, 64'd64);
      chk("fill rb1", {61'b0, rb1}, 64'd7);
      chk("fill bv1", bv1, 64'hFFFF_FFFF_FFFF_FFFF);

      cyc(); set_v[0] = 1'b1; set_i[0] = 6'd1;
      cyc(); set_i[0] = 6'd2;
      cyc(); set_i[0] = 6'd3;
      cyc(); set_v[0] = 1'b0; rd_en_a[0] = 3'b011; rd_i[0][0] = 6'd1; rd_i[0][1] = 6'd2;
      obs();
      chk("pre-reset cnt0", {58'b0, cnt0}, 64'd3);
      cyc(); reset = 1'b1;
      cyc(); reset = 1'b0;
      obs();
      chk("mid-reset bv0", {32'b0, bv0}, 64'h0);
      chk("mid-reset cnt0", {58'b0, cnt0}, 64'h0);
      chk("mid-reset rb0", {62'b0, rb0}, 64'h0);
      chk("mid-reset st0", {63'b0, st0}, 64'h0);
      chk("mid-reset cnt1", {57'b0, cnt1}, 64'h0);

      for (int n = 0; n < 2000; n++) begin
         cyc();
         reset = ($urandom_range(0, 63) == 0);
         for (int u = 0; u < 2; u++) begin
            set_v[u] = 1'($urandom_range(0, 1));
            set_i[u] = 6'($urandom_range(0, NREG[u] - 1));
            clr_v[u] = 1'($urandom_range(0, 1));
            clr_i[u] = ($urandom_range(0, 3) == 0) ? set_i[u]
                       : 6'($urandom_range(0, NREG[u] - 1));
            rd_en_a[u] = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
               rd_i[u][k] = ($urandom_range(0, 3) == 0) ? clr_i[u]
                            : 6'($urandom_range(0, NREG[u] - 1));
            end
         end
      end
      cyc();
      reset = 1'b0;
      idle_inputs();
      obs();
      obs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
